// File: rtl/car_speed_gen_pkg.sv
// Package car_pkg: shared definitions for the per-player engine/gearbox model.
//   - car_state_e : race state of one player (IDLE / RUN / BLOWN)
//   - widths      : RPM_W, DPOS_W, GEAR_W
//   - limits      : RPM_MAX, D_POS_MAX
//   - calc_dpos() : per-tick displacement from rpm and gear
package car_pkg;

    localparam int RPM_W     = 8;
    localparam int DPOS_W    = 5;
    localparam int GEAR_W    = 3;
    localparam int RPM_MAX   = 255;
    localparam int D_POS_MAX = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLOWN = 2'd2
    } car_state_e;

    // Displacement = min(31, (rpm[7:3] * gear) >> 2).
    // 31 * 7 = 217, so the product fits in 8 bits.
    function automatic logic [DPOS_W-1:0] calc_dpos(input logic [4:0]        rpm_hi,
                                                    input logic [GEAR_W-1:0] gear);
        logic [7:0] prod;
        logic [7:0] scaled;
        prod   = {3'b000, rpm_hi} * {5'b00000, gear};
        scaled = prod >> 2;
        if (scaled > 8'(D_POS_MAX)) begin
            return DPOS_W'(D_POS_MAX);
        end
        return scaled[DPOS_W-1:0];
    endfunction

endpackage

// File: rtl/car_speed_gen_if.sv
// Interface car_speed_gen_if: player controls and engine outputs of one
// car_speed_gen instance.
//   start      : one-cycle race-go pulse            (master -> slave)
//   gas        : debounced throttle level           (master -> slave)
//   shift_up   : one-cycle shift request            (master -> slave)
//   d_position : displacement per model tick        (slave -> master)
//   gear       : current gear 1..GEARS              (slave -> master)
//   rpm        : engine rpm 0..255                  (slave -> master)
//   blown      : engine blown                       (slave -> master)
// The master is the game-control side; the slave is car_speed_gen.
interface car_speed_gen_if;
    import car_pkg::*;

    logic                start;
    logic                gas;
    logic                shift_up;
    logic [DPOS_W-1:0]   d_position;
    logic [GEAR_W-1:0]   gear;
    logic [RPM_W-1:0]    rpm;
    logic                blown;

    modport master (
        output start, gas, shift_up,
        input  d_position, gear, rpm, blown
    );

    modport slave (
        input  start, gas, shift_up,
        output d_position, gear, rpm, blown
    );

endinterface

// File: rtl/car_speed_gen_tick_gen.sv
// Module tick_gen: model-tick clock enable for car_speed_gen.
// The counter runs 0..TICK_DIV-1; tick is high for the single cycle in which
// the counter sits at its last value, i.e. the cycle on which it wraps.
// This is a clock enable, not a derived clock.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   tick : one-cycle enable pulse every TICK_DIV cycles
module tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/car_speed_gen.sv
// Module car_speed_gen: per-player engine/gearbox model.
// Produces the 5-bit per-tick displacement that the position accumulator
// integrates. All model updates happen on tick cycles from tick_gen; start and
// shift_up pulses are latched on any cycle and consumed at the next tick.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : car_speed_gen_if.slave (start, gas, shift_up in;
//          d_position, gear, rpm, blown out, all registered)
// Optional feature macro: SPEED_GEN_LAUNCH_EN
//   defined     : launch control; rpm follows gas in IDLE, clamped at RPM_LAUNCH,
//                 and RUN starts from the held rpm.
//   not defined : rpm is forced to 0 in IDLE.
module car_speed_gen
    import car_pkg::*;
#(
    parameter int TICK_DIV      = 1000000,
    parameter int GEARS         = 5,
    parameter int RPM_INC       = 6,
    parameter int RPM_DEC       = 3,
    parameter int SHIFT_LOCK    = 20,
    parameter int OVERREV_TICKS = 100
`ifdef SPEED_GEN_LAUNCH_EN
    ,
    parameter int RPM_LAUNCH    = 160
`endif
) (
    input  logic            clk,
    input  logic            rst,
    car_speed_gen_if.slave  bus
);

    localparam int LOCK_W = $clog2(SHIFT_LOCK + 1);
    localparam int OVR_W  = $clog2(OVERREV_TICKS + 1);

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    car_state_e        state_q,      state_d;
    logic [RPM_W-1:0]  rpm_q,        rpm_d;
    logic [GEAR_W-1:0] gear_q,       gear_d;
    logic [DPOS_W-1:0] dpos_q,       dpos_d;
    logic              blown_q,      blown_d;
    logic [LOCK_W-1:0] lock_q,       lock_d;
    logic [OVR_W-1:0]  ovr_q,        ovr_d;
    logic              start_pend_q, start_pend_d;
    logic              shift_pend_q, shift_pend_d;

    logic              start_req;
    logic              shift_req;
    logic [RPM_W:0]    rpm_inc9;
    logic [RPM_W:0]    rpm_dec9;
    logic [RPM_W-1:0]  rpm_up;
    logic [RPM_W-1:0]  rpm_dn;

    always_comb begin
        state_d      = state_q;
        rpm_d        = rpm_q;
        gear_d       = gear_q;
        dpos_d       = dpos_q;
        lock_d       = lock_q;
        ovr_d        = ovr_q;

        // A request arriving on the tick cycle itself is consumed by that tick.
        start_req    = start_pend_q | bus.start;
        shift_req    = shift_pend_q | bus.shift_up;
        start_pend_d = start_req;
        shift_pend_d = shift_req;

        // Saturating rpm steps; bit 8 of the sum flags overflow, bit 8 of the
        // difference flags a borrow.
        rpm_inc9 = {1'b0, rpm_q} + (RPM_W+1)'(RPM_INC);
        rpm_dec9 = {1'b0, rpm_q} - (RPM_W+1)'(RPM_DEC);
        rpm_up   = (rpm_inc9 > (RPM_W+1)'(RPM_MAX)) ? RPM_W'(RPM_MAX) : rpm_inc9[RPM_W-1:0];
        rpm_dn   = rpm_dec9[RPM_W] ? '0 : rpm_dec9[RPM_W-1:0];

        if (tick) begin
            // Requests not used by this tick are dropped, never queued.
            start_pend_d = 1'b0;
            shift_pend_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
`ifdef SPEED_GEN_LAUNCH_EN
                    if (bus.gas) begin
                        rpm_d = (rpm_inc9 > (RPM_W+1)'(RPM_LAUNCH)) ? RPM_W'(RPM_LAUNCH)
                                                                    : rpm_inc9[RPM_W-1:0];
                    end else begin
                        rpm_d = rpm_dn;
                    end
`else
                    rpm_d = '0;
`endif
                    dpos_d = '0;
                    if (start_req) begin
                        state_d = ST_RUN;
                    end
                end

                ST_RUN: begin
                    // An accepted shift halves rpm instead of applying gas this tick.
                    if (shift_req && (gear_q < GEAR_W'(GEARS)) && (lock_q == '0)) begin
                        gear_d = gear_q + GEAR_W'(1);
                        rpm_d  = rpm_q >> 1;
                        lock_d = LOCK_W'(SHIFT_LOCK);
                    end else begin
                        rpm_d = bus.gas ? rpm_up : rpm_dn;
                        if (lock_q != '0) begin
                            lock_d = lock_q - LOCK_W'(1);
                        end
                    end

                    ovr_d = (rpm_d == RPM_W'(RPM_MAX)) ? ovr_q + OVR_W'(1) : '0;

                    if (ovr_d == OVR_W'(OVERREV_TICKS)) begin
                        state_d = ST_BLOWN;
                        rpm_d   = '0;
                        gear_d  = GEAR_W'(1);
                        dpos_d  = '0;
                        ovr_d   = '0;
                        lock_d  = '0;
                    end else begin
                        dpos_d  = calc_dpos(rpm_d[RPM_W-1:3], gear_d);
                    end
                end

                ST_BLOWN: begin
                    rpm_d  = '0;
                    gear_d = GEAR_W'(1);
                    dpos_d = '0;
                    if (start_req) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    rpm_d   = '0;
                    gear_d  = GEAR_W'(1);
                    dpos_d  = '0;
                end
            endcase
        end

        blown_d = (state_d == ST_BLOWN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rpm_q        <= '0;
            gear_q       <= GEAR_W'(1);
            dpos_q       <= '0;
            blown_q      <= 1'b0;
            lock_q       <= '0;
            ovr_q        <= '0;
            start_pend_q <= 1'b0;
            shift_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rpm_q        <= rpm_d;
            gear_q       <= gear_d;
            dpos_q       <= dpos_d;
            blown_q      <= blown_d;
            lock_q       <= lock_d;
            ovr_q        <= ovr_d;
            start_pend_q <= start_pend_d;
            shift_pend_q <= shift_pend_d;
        end
    end

    assign bus.d_position = dpos_q;
    assign bus.gear       = gear_q;
    assign bus.rpm        = rpm_q;
    assign bus.blown      = blown_q;

endmodule

// File: tb/tb_car_speed_gen.sv
// Testbench for car_speed_gen with a fast model tick (TICK_DIV=4).
// A behavioural model tracks the race per tick with plain integer arithmetic;
// every cycle the DUT outputs are compared against it, and directed scenarios
// add fixed expected values at their key points.
module tb_car_speed_gen;

    localparam int TICK_DIV      = 4;
    localparam int GEARS         = 5;
    localparam int RPM_INC       = 6;
    localparam int RPM_DEC       = 3;
    localparam int SHIFT_LOCK    = 20;
    localparam int OVERREV_TICKS = 100;
    localparam int RPM_LAUNCH    = 160;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_BLOWN = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    car_speed_gen_if bus_if ();

    car_speed_gen #(
        .TICK_DIV      (TICK_DIV),
        .GEARS         (GEARS),
        .RPM_INC       (RPM_INC),
        .RPM_DEC       (RPM_DEC),
        .SHIFT_LOCK    (SHIFT_LOCK),
        .OVERREV_TICKS (OVERREV_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_state;
    int m_rpm;
    int m_gear;
    int m_lock;
    int m_ovr;
    int m_dpos;
    int m_phase;
    int m_ticks;
    bit m_start_seen;
    bit m_shift_seen;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_state      = M_IDLE;
        m_rpm        = 0;
        m_gear       = 1;
        m_lock       = 0;
        m_ovr        = 0;
        m_dpos       = 0;
        m_phase      = 0;
        m_start_seen = 0;
        m_shift_seen = 0;
    endtask

    function automatic int gasStep(input int rpm, input bit gas, input int ceiling);
        int r;
        if (gas) begin
            r = rpm + RPM_INC;
            if (r > ceiling) r = ceiling;
        end else begin
            r = rpm - RPM_DEC;
            if (r < 0) r = 0;
        end
        return r;
    endfunction

    task automatic modelTick(input bit s, input bit sh, input bit g);
        int p;
        m_ticks++;
        if (m_state == M_IDLE) begin
`ifdef SPEED_GEN_LAUNCH_EN
            m_rpm = gasStep(m_rpm, g, RPM_LAUNCH);
`else
            m_rpm = 0;
`endif
            m_dpos = 0;
            if (s) m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (sh && m_gear < GEARS && m_lock == 0) begin
                m_gear = m_gear + 1;
                m_rpm  = m_rpm / 2;
                m_lock = SHIFT_LOCK;
            end else begin
                m_rpm = gasStep(m_rpm, g, 255);
                if (m_lock > 0) m_lock = m_lock - 1;
            end
            m_ovr = (m_rpm == 255) ? m_ovr + 1 : 0;
            if (m_ovr == OVERREV_TICKS) begin
                m_state = M_BLOWN;
                m_rpm   = 0;
                m_gear  = 1;
                m_dpos  = 0;
                m_ovr   = 0;
                m_lock  = 0;
            end else begin
                p = ((m_rpm / 8) * m_gear) / 4;
                m_dpos = (p > 31) ? 31 : p;
            end
        end else begin
            m_rpm  = 0;
            m_gear = 1;
            m_dpos = 0;
            if (s) m_state = M_IDLE;
        end
    endtask

    task automatic modelClock();
        bit s;
        bit sh;
        s  = m_start_seen || bus_if.start;
        sh = m_shift_seen || bus_if.shift_up;
        if (m_phase == TICK_DIV - 1) begin
            modelTick(s, sh, bus_if.gas);
            m_start_seen = 0;
            m_shift_seen = 0;
            m_phase      = 0;
        end else begin
            m_start_seen = s;
            m_shift_seen = sh;
            m_phase++;
        end
    endtask

    task automatic applyStimulus(input bit s, input bit g, input bit sh);
        bus_if.start    = s;
        bus_if.gas      = g;
        bus_if.shift_up = sh;
    endtask

    // One clock: advance the model on the edge, compare 1 time unit later.
    task automatic stepCycle();
        @(posedge clk);
        if (!rst) modelReset();
        else      modelClock();
        #1;
        checkOutput("rpm",   int'(bus_if.rpm),        m_rpm);
        checkOutput("gear",  int'(bus_if.gear),       m_gear);
        checkOutput("dpos",  int'(bus_if.d_position), m_dpos);
        checkOutput("blown", int'(bus_if.blown),      (m_state == M_BLOWN) ? 1 : 0);
    endtask

    task automatic runTicks(input int n);
        int t0;
        t0 = m_ticks;
        while (m_ticks < t0 + n) stepCycle();
    endtask

    task automatic pulseStart();
        int t0;
        t0 = m_ticks;
        bus_if.start = 1'b1;
        stepCycle();
        bus_if.start = 1'b0;
        while (m_ticks == t0) stepCycle();
    endtask

    task automatic pulseShift();
        int t0;
        t0 = m_ticks;
        bus_if.shift_up = 1'b1;
        stepCycle();
        bus_if.shift_up = 1'b0;
        while (m_ticks == t0) stepCycle();
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        stepCycle();
        stepCycle();
        checkOutput("reset_rpm",   int'(bus_if.rpm),        0);
        checkOutput("reset_gear",  int'(bus_if.gear),       1);
        checkOutput("reset_dpos",  int'(bus_if.d_position), 0);
        checkOutput("reset_blown", int'(bus_if.blown),      0);
        rst = 1'b1;
    endtask

    initial begin
        m_ticks = 0;
        modelReset();
        doReset();

        // Start, then 10 ticks of gas
        pulseStart();
        bus_if.gas = 1'b1;
        runTicks(10);
        checkOutput("t1_rpm",  int'(bus_if.rpm),        60);
        checkOutput("t1_gear", int'(bus_if.gear),       1);
        checkOutput("t1_dpos", int'(bus_if.d_position), 1);

        // Shift at 204 rpm halves rpm; a shift during the lock is dropped
        runTicks(24);
        checkOutput("t2_rpm_pre", int'(bus_if.rpm), 204);
        pulseShift();
        checkOutput("t2_gear", int'(bus_if.gear), 2);
        checkOutput("t2_rpm",  int'(bus_if.rpm),  102);
        bus_if.gas = 1'b0;
        runTicks(5);
        pulseShift();
        checkOutput("t2_locked_gear", int'(bus_if.gear), 2);
        checkOutput("t2_locked_rpm",  int'(bus_if.rpm),  84);

        // Climb to top gear, saturate displacement, shift at top gear ignored
        bus_if.gas = 1'b1;
        for (int i = 0; i < 6 && m_gear < GEARS; i++) begin
            runTicks(SHIFT_LOCK + 1);
            pulseShift();
        end
        checkOutput("t4_gear5", int'(bus_if.gear), 5);
        runTicks(25);
        checkOutput("t4_rpm_max", int'(bus_if.rpm),        255);
        checkOutput("t4_dpos",    int'(bus_if.d_position), 31);
        pulseShift();
        checkOutput("t4_gear_hold", int'(bus_if.gear), 5);

        // Overrev blows the engine; start -> IDLE, second start -> RUN
        runTicks(OVERREV_TICKS);
        checkOutput("t3_blown",      int'(bus_if.blown),      1);
        checkOutput("t3_blown_dpos", int'(bus_if.d_position), 0);
        checkOutput("t3_blown_gear", int'(bus_if.gear),       1);
        bus_if.gas = 1'b0;
        bus_if.shift_up = 1'b1;
        pulseStart();
        bus_if.shift_up = 1'b0;
        checkOutput("t3_idle_blown", int'(bus_if.blown), 0);
        pulseStart();
        bus_if.gas = 1'b1;
        runTicks(2);
        checkOutput("t3_run_rpm", int'(bus_if.rpm), 12);

        // Asynchronous reset between edges, with a start request pending
        runTicks(3);
        while (m_phase != 0) stepCycle();
        bus_if.start = 1'b1;
        stepCycle();
        bus_if.start = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t5_rpm",   int'(bus_if.rpm),        0);
        checkOutput("t5_gear",  int'(bus_if.gear),       1);
        checkOutput("t5_dpos",  int'(bus_if.d_position), 0);
        checkOutput("t5_blown", int'(bus_if.blown),      0);
        modelReset();
        stepCycle();
        stepCycle();
        rst = 1'b1;
        bus_if.gas = 1'b1;
        runTicks(3);
`ifdef SPEED_GEN_LAUNCH_EN
        checkOutput("t5_idle_rpm", int'(bus_if.rpm), 18);
`else
        checkOutput("t5_idle_rpm", int'(bus_if.rpm), 0);
`endif
        checkOutput("t5_idle_dpos", int'(bus_if.d_position), 0);

        // Randomized play against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 75),
                          ($urandom_range(0, 99) < 4));
            stepCycle();
        end

`ifdef SPEED_GEN_LAUNCH_EN
        // Launch control holds rpm in IDLE; RUN continues from it
        doReset();
        bus_if.gas = 1'b1;
        runTicks(30);
        checkOutput("t6_launch_rpm",  int'(bus_if.rpm),        RPM_LAUNCH);
        checkOutput("t6_launch_dpos", int'(bus_if.d_position), 0);
        pulseStart();
        runTicks(1);
        checkOutput("t6_first_run_rpm", int'(bus_if.rpm), RPM_LAUNCH + RPM_INC);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
